luma_hist: RTL



---
 rtl/luma_hist_if.sv | 27 ++
 rtl/luma_hist.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/luma_hist_if.sv
// Pixel tap, register read port and frame status of luma_hist.
// slave = histogram block, master = video source / MicroBlaze bridge side.
interface luma_hist_if;
   logic [7:0]  red_i;
   logic [7:0]  green_i;
   logic [7:0]  blue_i;
   logic        dv_i;
   logic        hs_i;
   logic        vs_i;
   logic        rd_strobe_i;
   logic [7:0]  rd_addr_i;
   logic        rd_ack_o;
   logic [31:0] rd_data_o;
   logic        frame_done_o;
   logic [31:0] frame_pixels_o;
   logic        clear_drop_o;

   modport slave (
      input  red_i, green_i, blue_i, dv_i, hs_i, vs_i, rd_strobe_i, rd_addr_i,
      output rd_ack_o, rd_data_o, frame_done_o, frame_pixels_o, clear_drop_o
   );

   modport master (
      output red_i, green_i, blue_i, dv_i, hs_i, vs_i, rd_strobe_i, rd_addr_i,
      input  rd_ack_o, rd_data_o, frame_done_o, frame_pixels_o, clear_drop_o
   );
endinterface

// File: rtl/luma_hist.sv
// Per-frame 256-bin luma histogram, double-banked; accumulate depth 4, read ack 2 cycles after strobe.
// Passive video tap: never stalls the stream; pixels arriving while a bank is drained/cleared are dropped.
module luma_hist #(
   parameter int COUNT_W        = 22,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   luma_hist_if.slave bus
);
   localparam logic [2:0] S_RESET_CLR = 3'd0;
   localparam logic [2:0] S_WAIT_VS   = 3'd1;
   localparam logic [2:0] S_ACCUM     = 3'd2;
   localparam logic [2:0] S_DRAIN     = 3'd3;
   localparam logic [2:0] S_CLEAR     = 3'd4;
   localparam logic [COUNT_W-1:0] CNT_MAX = '1;
   localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

   logic [2:0]  state_q, state_d;
   logic [7:0]  clr_addr_q, clr_addr_d;
   logic [1:0]  drain_cnt_q, drain_cnt_d;
   logic        active_q, active_d;
   logic        vs_q;
   logic [31:0] pix_cnt_q, pix_cnt_d;
   logic [31:0] frame_pixels_q, frame_pixels_d;
   logic        frame_done_q, frame_done_d;
   logic        clear_drop_q, clear_drop_d;
   logic        vs_rise;
   logic        take_pix;

   logic        p1_vld_q;
   logic [7:0]  p1_r_q, p1_g_q, p1_b_q;
   logic        p2_vld_q;
   logic [7:0]  p2_y_q;
   logic        p3_vld_q;
   logic [7:0]  p3_y_q;
   logic        wr_vld_q;
   logic [7:0]  wr_addr_q;
   logic [COUNT_W-1:0] wr_cnt_q;

   logic [15:0] luma_sum;
   logic [7:0]  luma_y;
   logic [7:0]  luma_frac_unused;
   logic [COUNT_W-1:0] acc_base, acc_cnt;
   logic        acc_we;

   logic [COUNT_W-1:0] bank0_mem [256];
   logic [COUNT_W-1:0] bank1_mem [256];
   logic [COUNT_W-1:0] bank0_q, bank1_q;
   logic [7:0]  bank0_raddr, bank1_raddr, bank_waddr;
   logic [COUNT_W-1:0] bank_wdat;
   logic        bank0_we, bank1_we;

   logic        rd_vld_q, rd_bank_q, rd_ack_q;
   logic [31:0] rd_data_q, rd_data_d;
   logic        unused_hs;

   // hsync carries nothing a histogram needs.
   assign unused_hs = bus.hs_i;
   assign vs_rise   = bus.vs_i & ~vs_q;

   always_comb begin
      state_d        = state_q;
      clr_addr_d     = clr_addr_q;
      drain_cnt_d    = drain_cnt_q;
      active_d       = active_q;
      pix_cnt_d      = pix_cnt_q;
      frame_pixels_d = frame_pixels_q;
      frame_done_d   = 1'b0;
      clear_drop_d   = clear_drop_q;
      take_pix       = 1'b0;
      case (state_q)
         S_RESET_CLR: begin
            clr_addr_d = clr_addr_q + 8'd1;
            if (clr_addr_q == 8'hFF) state_d = S_WAIT_VS;
         end
         S_WAIT_VS: begin
            if (vs_rise) state_d = S_ACCUM;
         end
         S_ACCUM: begin
            take_pix = bus.dv_i;
            if (bus.dv_i) pix_cnt_d = pix_cnt_q + 32'd1;
            if (vs_rise) begin
               state_d     = S_DRAIN;
               drain_cnt_d = 2'd0;
            end
         end
         S_DRAIN: begin
            if (bus.dv_i) clear_drop_d = 1'b1;
            drain_cnt_d = drain_cnt_q + 2'd1;
            // Four cycles covers the last pixel's write before the banks trade roles.
            if (drain_cnt_q == 2'd3) begin
               state_d        = S_CLEAR;
               active_d       = ~active_q;
               frame_pixels_d = pix_cnt_q;
               pix_cnt_d      = 32'd0;
               frame_done_d   = 1'b1;
               clr_addr_d     = 8'd0;
            end
         end
         S_CLEAR: begin
            if (bus.dv_i) clear_drop_d = 1'b1;
            clr_addr_d = clr_addr_q + 8'd1;
            if (clr_addr_q == 8'hFF) state_d = S_ACCUM;
         end
         default: state_d = S_WAIT_VS;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= CLEAR_ON_RESET ? S_RESET_CLR : S_WAIT_VS;
         clr_addr_q     <= 8'd0;
         drain_cnt_q    <= 2'd0;
         active_q       <= 1'b0;
         vs_q           <= 1'b0;
         pix_cnt_q      <= 32'd0;
         frame_pixels_q <= 32'd0;
         frame_done_q   <= 1'b0;
         clear_drop_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         clr_addr_q     <= clr_addr_d;
         drain_cnt_q    <= drain_cnt_d;
         active_q       <= active_d;
         vs_q           <= bus.vs_i;
         pix_cnt_q      <= pix_cnt_d;
         frame_pixels_q <= frame_pixels_d;
         frame_done_q   <= frame_done_d;
         clear_drop_q   <= clear_drop_d;
      end
   end

   assign luma_sum = 16'd77 * {8'd0, p1_r_q} + 16'd150 * {8'd0, p1_g_q} + 16'd29 * {8'd0, p1_b_q};
   assign {luma_y, luma_frac_unused} = luma_sum;

   // The bank read issued one cycle earlier misses a write landing on the same edge; take it from wr_*.
   assign acc_base = (wr_vld_q && (wr_addr_q == p3_y_q)) ? wr_cnt_q
                   : (active_q ? bank1_q : bank0_q);
   assign acc_cnt  = (acc_base == CNT_MAX) ? acc_base : acc_base + CNT_ONE;
   assign acc_we   = p3_vld_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         p1_vld_q <= 1'b0;
         p2_vld_q <= 1'b0;
         p3_vld_q <= 1'b0;
         wr_vld_q <= 1'b0;
         p1_r_q   <= 8'd0;
         p1_g_q   <= 8'd0;
         p1_b_q   <= 8'd0;
         p2_y_q   <= 8'd0;
         p3_y_q   <= 8'd0;
         wr_addr_q <= 8'd0;
         wr_cnt_q <= '0;
      end else begin
         p1_vld_q  <= take_pix;
         p1_r_q    <= bus.red_i;
         p1_g_q    <= bus.green_i;
         p1_b_q    <= bus.blue_i;
         p2_vld_q  <= p1_vld_q;
         p2_y_q    <= luma_y;
         p3_vld_q  <= p2_vld_q;
         p3_y_q    <= p2_y_q;
         wr_vld_q  <= acc_we;
         wr_addr_q <= p3_y_q;
         wr_cnt_q  <= acc_cnt;
      end
   end

   // Each bank: one read port shared by accumulate (active) and register reads (frozen), one write port.
   assign bank0_raddr = active_q ? bus.rd_addr_i : p2_y_q;
   assign bank1_raddr = active_q ? p2_y_q : bus.rd_addr_i;
   assign bank_waddr  = acc_we ? p3_y_q : clr_addr_q;
   assign bank_wdat   = acc_we ? acc_cnt : '0;
   assign bank0_we    = (state_q == S_RESET_CLR) || (!active_q && (acc_we || state_q == S_CLEAR));
   assign bank1_we    = (state_q == S_RESET_CLR) || ( active_q && (acc_we || state_q == S_CLEAR));

   always_ff @(posedge clk) begin
      if (bank0_we) bank0_mem[bank_waddr] <= bank_wdat;
      bank0_q <= bank0_mem[bank0_raddr];
   end

   always_ff @(posedge clk) begin
      if (bank1_we) bank1_mem[bank_waddr] <= bank_wdat;
      bank1_q <= bank1_mem[bank1_raddr];
   end

   always_comb begin
      rd_data_d = '0;
      rd_data_d[COUNT_W-1:0] = rd_bank_q ? bank1_q : bank0_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_vld_q  <= 1'b0;
         rd_bank_q <= 1'b0;
         rd_ack_q  <= 1'b0;
         rd_data_q <= 32'd0;
      end else begin
         rd_vld_q  <= bus.rd_strobe_i;
         rd_bank_q <= ~active_q;
         rd_ack_q  <= rd_vld_q;
         if (rd_vld_q) rd_data_q <= rd_data_d;
      end
   end

   assign bus.rd_ack_o       = rd_ack_q;
   assign bus.rd_data_o      = rd_data_q;
   assign bus.frame_done_o   = frame_done_q;
   assign bus.frame_pixels_o = frame_pixels_q;
   assign bus.clear_drop_o   = clear_drop_q;
endmodule
